hex_keypad_scanner: RTL



---
 rtl/keypad_pkg.sv | 38 +++
 rtl/keypad_scan_timer.sv | 42 ++++
 rtl/hex_keypad_scanner.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 hex keypad scanner.
//   ROWS/COLS     keypad geometry
//   state_t       debounce FSM states
//   snap_kind_t   per-frame snapshot classification (none / one key / several keys)
//   snap_t        snapshot = classification + key code
//   KEY_MAP       16 nibbles indexed {row,col}; key_map() looks one up
package keypad_pkg;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    REL_DB
  } state_t;

  typedef enum logic [1:0] {
    SNAP_NONE,
    SNAP_ONE,
    SNAP_MULTI
  } snap_kind_t;

  typedef struct packed {
    snap_kind_t kind;
    logic [3:0] code;
  } snap_t;

  // Entry {row,col} sits at bits [4*{row,col} +: 4].
  // r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E 0 F D
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[{row, col, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// keypad_scan_timer: row-slot timing for the keypad scan.
//   clk, rst        clock, synchronous active-high reset
//   row_n[3:0]      active-low row drive, exactly one bit low, rotates 1110->1101->1011->0111
//   row_idx[1:0]    index of the row currently driven
//   sample_stb      last cycle of a row slot: columns have settled, sample them now
//   frame_end_stb   sample_stb for row 3, i.e. the final sample of a frame
module keypad_scan_timer #(
  parameter int unsigned SCAN_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_n,
  output logic [1:0] row_idx,
  output logic       sample_stb,
  output logic       frame_end_stb
);

  localparam int unsigned CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_CYCLES - 1);

  logic [CW-1:0] slot_cnt;

  assign sample_stb    = (slot_cnt == SLOT_LAST);
  assign frame_end_stb = sample_stb && (row_idx == 2'd3);

  // Row drive is registered so the pins never glitch; it advances on the
  // cycle following the sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      row_idx  <= '0;
      row_n    <= 4'b1110;
    end else if (sample_stb) begin
      slot_cnt <= '0;
      row_idx  <= row_idx + 2'd1;
      row_n    <= {row_n[2:0], row_n[3]};
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner: scans a 4x4 hex keypad and delivers one debounced key
// code per press over a valid/ready handshake.
//   sys_clk, sys_rst   clock, synchronous active-high reset
//   row_n[3:0]         active-low row drive
//   col_n[3:0]         active-low column sense, asynchronous
//   key_code[3:0]      accepted code, stable while key_valid
//   key_valid          code available, held until key_ready
//   key_ready          consumer accepts on key_valid & key_ready
//   key_held           debounced "a single key is down"
//   overrun            sticky: a press was accepted while key_valid was pending
//   overrun_clr        one-cycle pulse clearing overrun (set wins)
module hex_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 50000,
  parameter int unsigned DEBOUNCE_FRAMES = 5
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun,
  input  logic       overrun_clr
);

  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_FRAMES);

  logic [1:0] row_idx;
  logic       sample_stb;
  logic       frame_end_stb;

  keypad_scan_timer #(.SCAN_CYCLES(SCAN_CYCLES)) u_timer (
    .clk           (sys_clk),
    .rst           (sys_rst),
    .row_n         (row_n),
    .row_idx       (row_idx),
    .sample_stb    (sample_stb),
    .frame_end_stb (frame_end_stb)
  );

  // Two-flop column synchronizer; idle level is all released.
  logic [3:0] col_meta, col_sync;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
    end
  end

  // Frame accumulator: saturating hit count (0, 1, 2+) and the code of the
  // first hit. The frame snapshot folds in the row-3 sample combinationally.
  logic [1:0] acc_hits, acc_hits_next, hits_row;
  logic [3:0] acc_code, acc_code_next;
  logic [2:0] hit_sum;
  logic [1:0] col_sel;
  logic [3:0] pressed;
  int         n_pressed;
  snap_t      snap;

  always_comb begin
    pressed   = ~col_sync;
    n_pressed = $countones(pressed);
    col_sel   = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (pressed[c]) col_sel = 2'(c);
    end
    hits_row      = (n_pressed >= 2) ? 2'd2 : 2'(n_pressed);
    hit_sum       = {1'b0, acc_hits} + {1'b0, hits_row};
    acc_hits_next = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    acc_code_next = acc_code;
    if (hits_row == 2'd1 && acc_hits == 2'd0) acc_code_next = key_map(row_idx, col_sel);
    snap.code = acc_code_next;
    case (acc_hits_next)
      2'd0:    snap.kind = SNAP_NONE;
      2'd1:    snap.kind = SNAP_ONE;
      default: snap.kind = SNAP_MULTI;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || frame_end_stb) begin
      acc_hits <= '0;
      acc_code <= '0;
    end else if (sample_stb) begin
      acc_hits <= acc_hits_next;
      acc_code <= acc_code_next;
    end
  end

  // Debounce FSM
  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic [3:0] cand, cand_next;
  logic       accept;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      cand  <= cand_next;
    end
  end

  // MULTI snapshots leave state and counter untouched in every state.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cand_next  = cand;
    accept     = 1'b0;
    if (frame_end_stb) begin
      unique case (state)
        IDLE: begin
          if (snap.kind == SNAP_ONE) begin
            cand_next = snap.code;
            if (DB_LAST <= 4'd1) begin
              state_next = PRESSED;
              cnt_next   = '0;
              accept     = 1'b1;
            end else begin
              state_next = PRESS_DB;
              cnt_next   = 4'd1;
            end
          end
        end
        PRESS_DB: begin
          if (snap.kind == SNAP_NONE) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (snap.kind == SNAP_ONE) begin
            if (snap.code == cand) begin
              if (cnt + 4'd1 >= DB_LAST) begin
                state_next = PRESSED;
                cnt_next   = '0;
                accept     = 1'b1;
              end else begin
                cnt_next = cnt + 4'd1;
              end
            end else begin
              cand_next = snap.code;
              cnt_next  = 4'd1;
            end
          end
        end
        PRESSED: begin
          if (snap.kind == SNAP_NONE) begin
            if (DB_LAST <= 4'd1) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else begin
              state_next = REL_DB;
              cnt_next   = 4'd1;
            end
          end
        end
        REL_DB: begin
          if (snap.kind == SNAP_NONE) begin
            if (cnt + 4'd1 >= DB_LAST) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt + 4'd1;
            end
          end else if (snap.kind == SNAP_ONE) begin
            state_next = PRESSED;
            cnt_next   = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    key_held = (state == PRESSED) || (state == REL_DB);
  end

  // Output handshake: an accepted code loads only if the slot is free or
  // being drained this cycle; otherwise the old code stays and overrun sets.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept && (!key_valid || key_ready)) begin
        key_code  <= cand_next;
        key_valid <= 1'b1;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
      if (accept && key_valid && !key_ready) overrun <= 1'b1;
      else if (overrun_clr)                  overrun <= 1'b0;
    end
  end

endmodule
